mem_copy_master: RTL and testbench

- Initiator for the shared 40-bit mem_req/mem_resp interface. It drives the requester side that ExtMem and the other memory responders serve.
- Takes one copy command: source address, destination address and a doubleword count. It then runs alternating 64-bit read and write requests, with one request outstanding at a time, and reports completion.
- Sits between the accelerator control logic and the external memory port.

---
 rtl/mem_if_pkg.sv | 19 +
 rtl/mem_copy_master.sv | 160 ++++++++++++++++
 tb/tb_mem_copy_master.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the 40-bit mem_req/mem_resp requester interface
// and the copy-engine state encoding.
package mem_if_pkg;

    localparam logic [4:0] MEM_CMD_RD = 5'd0;
    localparam logic [4:0] MEM_CMD_WR = 5'd1;
    localparam logic [2:0] MEM_TYP_D  = 3'd0;
    localparam int         DW_BYTES   = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/mem_copy_master.sv
// Doubleword copy engine: alternates single outstanding 64-bit reads and writes
// on the mem_req/mem_resp interface, then pulses done_o.
module mem_copy_master
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = 40,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_src_addr_i,
    input  logic [ADDR_W-1:0] cmd_dst_addr_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    input  logic              mem_req_ready_i,
    output logic              mem_req_valid_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [4:0]        mem_req_cmd_o,
    output logic [2:0]        mem_req_typ_o,
    output logic [63:0]       mem_req_data_o,
    input  logic              mem_resp_valid_i,
    input  logic [ADDR_W-1:0] mem_resp_addr_i,
    input  logic [4:0]        mem_resp_cmd_i,
    input  logic [2:0]        mem_resp_typ_i,
    input  logic [63:0]       mem_resp_data_i
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [4:0]        req_cmd_q, req_cmd_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [63:0]       data_q, data_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] src_aligned, dst_aligned, src_inc, dst_inc;
    logic [LEN_W-1:0]  len_dec;
    logic              unused_resp;

    // Echoed address/size are not checked; low address bits are dropped on alignment.
    assign unused_resp = ^{mem_resp_addr_i, mem_resp_typ_i,
                           cmd_src_addr_i[2:0], cmd_dst_addr_i[2:0]};

    assign src_aligned = {cmd_src_addr_i[ADDR_W-1:3], 3'b000};
    assign dst_aligned = {cmd_dst_addr_i[ADDR_W-1:3], 3'b000};
    assign src_inc     = src_q + ADDR_W'(DW_BYTES);
    assign dst_inc     = dst_q + ADDR_W'(DW_BYTES);
    assign len_dec     = len_q - LEN_W'(1);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        req_addr_d = req_addr_q;
        req_cmd_d  = req_cmd_q;
        len_d      = len_q;
        data_d     = data_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    src_d = src_aligned;
                    dst_d = dst_aligned;
                    len_d = cmd_len_i;
                    err_d = 1'b0;
                    if (cmd_len_i == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = RD_REQ;
                        req_addr_d = src_aligned;
                        req_cmd_d  = MEM_CMD_RD;
                    end
                end
                // A stray response wins over the error clear of a same-cycle command.
                if (mem_resp_valid_i) err_d = 1'b1;
            end
            RD_REQ: begin
                if (mem_resp_valid_i) err_d = 1'b1;
                if (mem_req_ready_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_resp_valid_i) begin
                    if (mem_resp_cmd_i == MEM_CMD_RD) begin
                        data_d     = mem_resp_data_i;
                        req_addr_d = dst_q;
                        req_cmd_d  = MEM_CMD_WR;
                        state_d    = WR_REQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            WR_REQ: begin
                if (mem_resp_valid_i) err_d = 1'b1;
                if (mem_req_ready_i) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (mem_resp_valid_i) begin
                    if (mem_resp_cmd_i == MEM_CMD_WR) begin
                        src_d = src_inc;
                        dst_d = dst_inc;
                        len_d = len_dec;
                        if (len_dec == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d    = RD_REQ;
                            req_addr_d = src_inc;
                            req_cmd_d  = MEM_CMD_RD;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields only change on entry to a REQ state, so they hold through the response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            req_addr_q <= '0;
            req_cmd_q  <= '0;
            len_q      <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            req_addr_q <= req_addr_d;
            req_cmd_q  <= req_cmd_d;
            len_q      <= len_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    assign cmd_ready_o     = (state_q == IDLE);
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign err_o           = err_q;
    assign mem_req_valid_o = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign mem_req_addr_o  = req_addr_q;
    assign mem_req_cmd_o   = req_cmd_q;
    assign mem_req_typ_o   = MEM_TYP_D;
    assign mem_req_data_o  = data_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed bench for mem_copy_master with a 2-cycle memory responder model.
module tb_mem_copy_master;

    typedef struct {
        logic [39:0] addr;
        logic [4:0]  cmd;
        logic [63:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [39:0] cmd_src_addr_i;
    logic [39:0] cmd_dst_addr_i;
    logic [15:0] cmd_len_i;
    logic        busy_o, done_o, err_o;
    logic        mem_req_ready_i;
    logic        mem_req_valid_o;
    logic [39:0] mem_req_addr_o;
    logic [4:0]  mem_req_cmd_o;
    logic [2:0]  mem_req_typ_o;
    logic [63:0] mem_req_data_o;
    logic        mem_resp_valid_i;
    logic [39:0] mem_resp_addr_i;
    logic [4:0]  mem_resp_cmd_i;
    logic [2:0]  mem_resp_typ_i;
    logic [63:0] mem_resp_data_i;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] mem [logic [39:0]];
    req_t        log_q[$];
    logic        bad_rd = 1'b0;
    logic        spurious = 1'b0;

    mem_copy_master #(.ADDR_W(40), .LEN_W(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_src_addr_i(cmd_src_addr_i), .cmd_dst_addr_i(cmd_dst_addr_i),
        .cmd_len_i(cmd_len_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .mem_req_ready_i(mem_req_ready_i), .mem_req_valid_o(mem_req_valid_o),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_cmd_o(mem_req_cmd_o),
        .mem_req_typ_o(mem_req_typ_o), .mem_req_data_o(mem_req_data_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_addr_i(mem_resp_addr_i),
        .mem_resp_cmd_i(mem_resp_cmd_i), .mem_resp_typ_i(mem_resp_typ_i),
        .mem_resp_data_i(mem_resp_data_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Responder: answers each accepted request in the second cycle after the handshake.
    initial begin
        int   cnt;
        logic hs;
        req_t cur, pend;
        cnt = 0;
        pend.addr = '0; pend.cmd = '0; pend.data = '0;
        forever begin
            @(negedge clk);
            hs = reset && mem_req_valid_o && mem_req_ready_i;
            cur.addr = mem_req_addr_o;
            cur.cmd  = mem_req_cmd_o;
            cur.data = mem_req_data_o;
            if (reset && mem_resp_valid_i && !spurious) begin
                check("held_addr", 64'(mem_req_addr_o), 64'(pend.addr));
                check("held_cmd",  64'(mem_req_cmd_o),  64'(pend.cmd));
                check("held_data", mem_req_data_o,      pend.data);
            end
            @(posedge clk);
            #1;
            mem_resp_valid_i = 1'b0;
            if (!reset) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem_resp_valid_i = 1'b1;
                    mem_resp_addr_i  = pend.addr;
                    mem_resp_typ_i   = 3'd0;
                    mem_resp_cmd_i   = (bad_rd && pend.cmd == 5'd0) ? 5'd1 : pend.cmd;
                    mem_resp_data_i  = (pend.cmd == 5'd0 && mem.exists(pend.addr)) ? mem[pend.addr] : 64'd0;
                end
            end
            if (hs) begin
                pend = cur;
                log_q.push_back(cur);
                if (cur.cmd == 5'd1) mem[cur.addr] = cur.data;
                cnt = 1;
            end
            if (spurious) begin
                spurious         = 1'b0;
                mem_resp_valid_i = 1'b1;
                mem_resp_cmd_i   = 5'd0;
            end
        end
    end

    task automatic run_cmd(input logic [39:0] src, input logic [39:0] dst, input logic [15:0] len,
                           input int stall, output int done_at, output int ndone,
                           output int busy_cnt, output logic err_done);
        logic [39:0] src_al;
        src_al = {src[39:3], 3'b000};
        check("cmd_ready_idle", 64'(cmd_ready_o), 64'd1);
        log_q.delete();
        cmd_src_addr_i = src;
        cmd_dst_addr_i = dst;
        cmd_len_i      = len;
        cmd_valid_i    = 1'b1;
        if (stall > 0) mem_req_ready_i = 1'b0;
        done_at = -1; ndone = 0; busy_cnt = 0; err_done = 1'bx;
        for (int k = 1; k < 300; k++) begin
            tick();
            cmd_valid_i     = 1'b0;
            mem_req_ready_i = (k > stall);
            if (stall > 0 && k <= stall + 1) begin
                check("stall_valid", 64'(mem_req_valid_o), 64'd1);
                check("stall_addr",  64'(mem_req_addr_o),  64'(src_al));
                check("stall_cmd",   64'(mem_req_cmd_o),   64'd0);
                check("stall_typ",   64'(mem_req_typ_o),   64'd0);
            end
            if (busy_o) busy_cnt++;
            if (done_o) begin
                ndone++;
                if (done_at < 0) begin
                    done_at  = k;
                    err_done = err_o;
                end
            end
            if (done_at >= 0 && k == done_at + 1) check("busy_after_done", 64'(busy_o), 64'd0);
            if (done_at >= 0 && k >= done_at + 3) break;
        end
        check("done_seen", 64'(done_at >= 0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   done_at, ndone, busy_cnt;
        logic err_done;
        reset = 1'b0; cmd_valid_i = 1'b0; cmd_src_addr_i = '0; cmd_dst_addr_i = '0;
        cmd_len_i = '0; mem_req_ready_i = 1'b1; mem_resp_valid_i = 1'b0;
        mem_resp_addr_i = '0; mem_resp_cmd_i = '0; mem_resp_typ_i = '0; mem_resp_data_i = '0;
        mem[40'h1000] = 64'hDEADBEEF_00000001;
        mem[40'h1008] = 64'h01234567_89ABCDEF;

        #3;
        check("rst_ready", 64'(cmd_ready_o), 64'd1);
        check("rst_busy",  64'(busy_o),      64'd0);
        check("rst_done",  64'(done_o),      64'd0);
        check("rst_err",   64'(err_o),       64'd0);
        check("rst_valid", 64'(mem_req_valid_o), 64'd0);
        check("rst_addr",  64'(mem_req_addr_o),  64'd0);
        check("rst_data",  mem_req_data_o,       64'd0);
        tick();
        reset = 1'b1;
        tick();

        // Two-doubleword copy: 6 cycles per doubleword plus the DONE cycle.
        run_cmd(40'h1000, 40'h2000, 16'd2, 0, done_at, ndone, busy_cnt, err_done);
        check("c2_done_at", 64'(done_at), 64'd13);
        check("c2_ndone",   64'(ndone),   64'd1);
        check("c2_busy",    64'(busy_cnt), 64'd13);
        check("c2_err",     64'(err_done), 64'd0);
        check("c2_nreq",    64'(log_q.size()), 64'd4);
        if (log_q.size() == 4) begin
            check("c2_r0_addr", 64'(log_q[0].addr), 64'h1000);
            check("c2_r0_cmd",  64'(log_q[0].cmd),  64'd0);
            check("c2_r1_addr", 64'(log_q[1].addr), 64'h2000);
            check("c2_r1_cmd",  64'(log_q[1].cmd),  64'd1);
            check("c2_r1_data", log_q[1].data,      64'hDEADBEEF_00000001);
            check("c2_r2_addr", 64'(log_q[2].addr), 64'h1008);
            check("c2_r2_cmd",  64'(log_q[2].cmd),  64'd0);
            check("c2_r3_addr", 64'(log_q[3].addr), 64'h2008);
            check("c2_r3_cmd",  64'(log_q[3].cmd),  64'd1);
            check("c2_r3_data", log_q[3].data,      64'h01234567_89ABCDEF);
        end

        // Zero-length command: straight to DONE, no requests.
        run_cmd(40'h1000, 40'h2000, 16'd0, 0, done_at, ndone, busy_cnt, err_done);
        check("c0_done_at", 64'(done_at), 64'd1);
        check("c0_ndone",   64'(ndone),   64'd1);
        check("c0_busy",    64'(busy_cnt), 64'd1);
        check("c0_nreq",    64'(log_q.size()), 64'd0);

        // Unaligned addresses are truncated to doubleword boundaries.
        run_cmd(40'h1003, 40'h2005, 16'd1, 0, done_at, ndone, busy_cnt, err_done);
        check("ua_done_at", 64'(done_at), 64'd7);
        check("ua_nreq",    64'(log_q.size()), 64'd2);
        if (log_q.size() == 2) begin
            check("ua_rd_addr", 64'(log_q[0].addr), 64'h1000);
            check("ua_wr_addr", 64'(log_q[1].addr), 64'h2000);
            check("ua_wr_data", log_q[1].data,      64'hDEADBEEF_00000001);
        end

        // Read request stalled 5 cycles by ready low.
        run_cmd(40'h1008, 40'h3000, 16'd1, 5, done_at, ndone, busy_cnt, err_done);
        check("st_done_at", 64'(done_at), 64'd12);
        check("st_nreq",    64'(log_q.size()), 64'd2);
        check("st_mem",     mem[40'h3000], 64'h01234567_89ABCDEF);

        // Read answered with a write command: error, no write issued.
        bad_rd = 1'b1;
        run_cmd(40'h1000, 40'h4000, 16'd2, 0, done_at, ndone, busy_cnt, err_done);
        bad_rd = 1'b0;
        check("be_done_at", 64'(done_at), 64'd4);
        check("be_ndone",   64'(ndone),   64'd1);
        check("be_err",     64'(err_done), 64'd1);
        check("be_nreq",    64'(log_q.size()), 64'd1);
        check("be_sticky",  64'(err_o),   64'd1);
        run_cmd(40'h1000, 40'h2000, 16'd0, 0, done_at, ndone, busy_cnt, err_done);
        check("be_cleared", 64'(err_done), 64'd0);

        // Stray response in IDLE flags an error without leaving IDLE.
        spurious = 1'b1;
        tick();
        tick();
        check("sp_err",   64'(err_o),       64'd1);
        check("sp_ready", 64'(cmd_ready_o), 64'd1);
        check("sp_busy",  64'(busy_o),      64'd0);
        tick();

        // Reset during WR_WAIT of a 3-doubleword copy.
        cmd_src_addr_i = 40'h1000; cmd_dst_addr_i = 40'h5000; cmd_len_i = 16'd3;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        repeat (4) tick();
        check("rw_busy_pre", 64'(busy_o), 64'd1);
        check("rw_valid_pre", 64'(mem_req_valid_o), 64'd0);
        reset = 1'b0;
        #1;
        check("rw_ready", 64'(cmd_ready_o), 64'd1);
        check("rw_busy",  64'(busy_o),      64'd0);
        check("rw_done",  64'(done_o),      64'd0);
        check("rw_err",   64'(err_o),       64'd0);
        check("rw_valid", 64'(mem_req_valid_o), 64'd0);
        check("rw_addr",  64'(mem_req_addr_o),  64'd0);
        check("rw_data",  mem_req_data_o,       64'd0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 2) reset = 1'b1;
            if (done_o || mem_req_valid_o) ndone++;
        end
        check("rw_quiet", 64'(ndone), 64'd0);
        check("rw_err_after", 64'(err_o), 64'd0);

        run_cmd(40'h1008, 40'h6000, 16'd1, 0, done_at, ndone, busy_cnt, err_done);
        check("rc_done_at", 64'(done_at), 64'd7);
        check("rc_err",     64'(err_done), 64'd0);
        check("rc_mem",     mem[40'h6000], 64'h01234567_89ABCDEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
